operand_extend_stage: RTL and testbench

//  Parametrised immediate/shamt extension unit, registered as one decoupled pipeline stage.

---
 rtl/operand_extend_stage.sv | 176 +++++++++++++++++
 tb/tb_operand_extend_stage.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_extend_stage.sv
// -----------------------------------------------------------------------------
// operand_extend_stage
//
// Extends a raw immediate/shamt field of IN_W bits to OUT_W bits. The stage is
// registered, sits between decode and the ID/EX operand path, and uses a
// 2-entry skid buffer so it sustains one transfer per cycle under valid/ready
// backpressure. An opaque tag travels with each datum.
//
// Extension modes (in_mode):
//   2'b00  zero   : upper bits filled with 0
//   2'b01  sign   : upper bits filled with in_data[IN_W-1]
//   2'b10  upper  : in_data placed in the top IN_W bits, low bits 0 (LUI style)
//   2'b11  branch : sign-extended value shifted left by 2, truncated to OUT_W
//
// Ports:
//   Clk        in   1      clock, rising edge
//   Reset      in   1      synchronous, active-high
//   in_valid   in   1      producer offers in_data/in_mode/in_tag
//   in_ready   out  1      stage accepts this cycle
//   in_data    in   IN_W   raw field
//   in_mode    in   2      extension mode (see above)
//   in_tag     in   TAG_W  sideband, passed through unchanged
//   out_valid  out  1      out_data/out_tag valid
//   out_ready  in   1      consumer accepts this cycle
//   out_data   out  OUT_W  extended result (entry A)
//   out_tag    out  TAG_W  tag of the result (entry A)
//   occupancy  out  2      entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module operand_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  localparam int EXT_W = OUT_W - IN_W;

  // The state encoding equals the number of entries held, so occupancy is
  // simply the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Entry A is the head and drives the outputs; entry B is the skid slot.
  logic [OUT_W-1:0] a_data_q, a_data_d;
  logic [TAG_W-1:0] a_tag_q,  a_tag_d;
  logic [OUT_W-1:0] b_data_q, b_data_d;
  logic [TAG_W-1:0] b_tag_q,  b_tag_d;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_data;
  logic             accept;
  logic             emit;

  // ---------------------------------------------------------------------------
  // Extension at the input; entries store the already-extended value, so the
  // mode only matters in the cycle the datum is accepted.
  // ---------------------------------------------------------------------------
  assign zext = OUT_W'(in_data);
  assign sext = OUT_W'($signed(in_data));

  always_comb begin
    ext_data = zext;
    case (in_mode)
      2'b00:   ext_data = zext;
      2'b01:   ext_data = sext;
      2'b10:   ext_data = zext << EXT_W;  // EXT_W == 0 leaves in_data as is
      2'b11:   ext_data = sext << 2;      // top two bits fall off the end
      default: ext_data = zext;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake. in_ready depends only on registered state and Reset, so there
  // is no combinational path from out_ready to in_ready.
  // ---------------------------------------------------------------------------
  assign in_ready  = !Reset && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = a_data_q;
  assign out_tag   = a_tag_q;
  assign occupancy = state_q;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state / entry update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_data_d = a_data_q;
    a_tag_d  = a_tag_q;
    b_data_d = b_data_q;
    b_tag_d  = b_tag_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          a_data_d = ext_data;
          a_tag_d  = in_tag;
        end
      end

      ONE: begin
        case ({accept, emit})
          2'b10: begin
            // Head is stalled; new datum parks in the skid slot.
            state_d  = FULL;
            b_data_d = ext_data;
            b_tag_d  = in_tag;
          end
          2'b01: begin
            state_d = EMPTY;
          end
          2'b11: begin
            // Head leaves and the new datum replaces it in the same cycle.
            state_d  = ONE;
            a_data_d = ext_data;
            a_tag_d  = in_tag;
          end
          default: begin
            state_d = ONE;
          end
        endcase
      end

      FULL: begin
        // in_ready is low here, so only the head can move.
        if (emit) begin
          state_d  = ONE;
          a_data_d = b_data_q;
          a_tag_d  = b_tag_q;
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= EMPTY;
      a_data_q <= '0;
      a_tag_q  <= '0;
      b_data_q <= '0;
      b_tag_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_data_q <= a_data_d;
      a_tag_q  <= a_tag_d;
      b_data_q <= b_data_d;
      b_tag_q  <= b_tag_d;
    end
  end

endmodule

// File: tb/tb_operand_extend_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_extend_stage
//
// Scoreboard bench for operand_extend_stage. Stimulus tasks push the expected
// extended value and tag when a transfer into the stage happens; a separate
// monitor pops and compares whenever the stage emits. A 16-bit and a 5-bit
// instance share clock and reset.
// -----------------------------------------------------------------------------
module tb_operand_extend_stage;

  logic        clk;
  logic        rst;

  // 16 -> 32 instance
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;

  // 5 -> 32 instance, consumer always ready
  logic        v5;
  logic        r5;
  logic [4:0]  d5;
  logic [1:0]  m5;
  logic [4:0]  t5;
  logic        ov5;
  logic [31:0] od5;
  logic [4:0]  ot5;
  logic [1:0]  oc5;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_data[$];
  logic [4:0]  exp_tag[$];
  logic [31:0] exp5_data[$];
  logic [4:0]  exp5_tag[$];

  operand_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  operand_extend_stage #(.IN_W(5), .OUT_W(32), .TAG_W(5)) dut5 (
    .Clk       (clk),
    .Reset     (rst),
    .in_valid  (v5),
    .in_ready  (r5),
    .in_data   (d5),
    .in_mode   (m5),
    .in_tag    (t5),
    .out_valid (ov5),
    .out_ready (1'b1),
    .out_data  (od5),
    .out_tag   (ot5),
    .occupancy (oc5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference for the 16 -> 32 extension.
  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] s;
    s = d[15] ? (32'hFFFF0000 | {16'h0000, d}) : {16'h0000, d};
    case (m)
      2'b00:   return {16'h0000, d};
      2'b01:   return s;
      2'b10:   return {d, 16'h0000};
      default: return {s[29:0], 2'b00};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Offer one datum to the 16-bit instance; called at posedge+1, returns at
  // posedge+1 after the accepting edge.
  task automatic drive(input logic [15:0] d, input logic [1:0] m,
                       input logic [4:0] t, input logic [31:0] e);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_data.push_back(e);
        exp_tag.push_back(t);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive_timeout: tag %0d never accepted", t);
    end
  endtask

  task automatic drive5(input logic [4:0] d, input logic [1:0] m,
                        input logic [4:0] t, input logic [31:0] e);
    bit done;
    done = 1'b0;
    v5   = 1'b1;
    d5   = d;
    m5   = m;
    t5   = t;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (r5) begin
        exp5_data.push_back(e);
        exp5_tag.push_back(t);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    v5 = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive5_timeout: tag %0d never accepted", t);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every emitted result against the scoreboard and checks
  // that a stalled head does not change.
  // ---------------------------------------------------------------------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic [4:0]  prev_tag   = '0;

  initial begin : monitor
    logic [31:0] ed;
    logic [4:0]  et;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid) begin
          n_cmp++;
          if (out_data !== prev_data || out_tag !== prev_tag) begin
            n_err++;
            $display("FAIL stall_hold: data %h tag %0d, required %h tag %0d",
                     out_data, out_tag, prev_data, prev_tag);
          end
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if (exp_data.size() == 0) begin
            n_err++;
            $display("FAIL out_underflow: emitted %h tag %0d, required nothing", out_data, out_tag);
          end else begin
            ed = exp_data.pop_front();
            et = exp_tag.pop_front();
            if (out_data !== ed || out_tag !== et) begin
              n_err++;
              $display("FAIL out_result: data %h tag %0d, required %h tag %0d",
                       out_data, out_tag, ed, et);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;

        if (ov5) begin
          n_cmp++;
          if (exp5_data.size() == 0) begin
            n_err++;
            $display("FAIL out5_underflow: emitted %h tag %0d, required nothing", od5, ot5);
          end else begin
            ed = exp5_data.pop_front();
            et = exp5_tag.pop_front();
            if (od5 !== ed || ot5 !== et) begin
              n_err++;
              $display("FAIL out5_result: data %h tag %0d, required %h tag %0d", od5, ot5, ed, et);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    bit acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    v5        = 1'b0;
    d5        = '0;
    m5        = '0;
    t5        = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_occupancy", {30'b0, occupancy}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_tag",   {27'b0, out_tag},   32'd0);
    chk("rst_in_ready5", {31'b0, r5},        32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Mode sweep, back to back, consumer always ready.
    out_ready = 1'b1;
    drive(16'h8000, 2'b00, 5'd1, 32'h00008000);
    chk("sweep_latency_valid", {31'b0, out_valid}, 32'd1);
    chk("sweep_occ", {30'b0, occupancy}, 32'd1);
    drive(16'h8000, 2'b01, 5'd2, 32'hFFFF8000);
    chk("sweep_occ", {30'b0, occupancy}, 32'd1);
    drive(16'h1234, 2'b10, 5'd3, 32'h12340000);
    chk("sweep_occ", {30'b0, occupancy}, 32'd1);
    drive(16'hFFFF, 2'b11, 5'd4, 32'hFFFFFFFC);
    chk("sweep_occ", {30'b0, occupancy}, 32'd1);
    drive(16'h7FFF, 2'b11, 5'd5, 32'h0001FFFC);
    chk("sweep_occ", {30'b0, occupancy}, 32'd1);
    @(posedge clk);
    #1;
    chk("sweep_drained_occ", {30'b0, occupancy}, 32'd0);

    // Backpressure: two entries held, head frozen.
    out_ready = 1'b0;
    drive(16'hABCD, 2'b01, 5'd1, 32'hFFFFABCD);
    drive(16'h0042, 2'b10, 5'd2, 32'h00420000);
    chk("bp_occ_full",    {30'b0, occupancy}, 32'd2);
    chk("bp_in_ready",    {31'b0, in_ready},  32'd0);
    chk("bp_head_tag",    {27'b0, out_tag},   32'd1);
    chk("bp_head_data",   out_data,           32'hFFFFABCD);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_frozen_data", out_data,           32'hFFFFABCD);
    chk("bp_still_full",  {30'b0, occupancy}, 32'd2);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_after_emit_occ",   {30'b0, occupancy}, 32'd1);
    chk("bp_after_emit_ready", {31'b0, in_ready},  32'd1);
    chk("bp_after_emit_tag",   {27'b0, out_tag},   32'd2);
    @(posedge clk);
    #1;
    chk("bp_drained_occ", {30'b0, occupancy}, 32'd0);

    // Simultaneous accept and emit for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      drive(16'h8000 | 16'(i), 2'b01, 5'(i), 32'hFFFF8000 | 32'(i));
      chk("ae_occ_one", {30'b0, occupancy}, 32'd1);
    end
    @(posedge clk);
    #1;
    chk("ae_drained_occ", {30'b0, occupancy}, 32'd0);

    // Reset while full discards both entries.
    out_ready = 1'b0;
    drive(16'h1111, 2'b00, 5'd7, 32'h00001111);
    drive(16'h2222, 2'b00, 5'd8, 32'h00002222);
    chk("rstmid_occ_before", {30'b0, occupancy}, 32'd2);
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready_low", {31'b0, in_ready}, 32'd0);
    exp_data.delete();
    exp_tag.delete();
    @(posedge clk);
    #1;
    chk("rstmid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid_occ",       {30'b0, occupancy}, 32'd0);
    chk("rstmid_out_data",  out_data,           32'd0);
    chk("rstmid_out_tag",   {27'b0, out_tag},   32'd0);
    chk("rstmid_in_ready_still_low", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_in_ready_high", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Narrow instance.
    drive5(5'h1F, 2'b00, 5'd1, 32'h0000001F);
    drive5(5'h10, 2'b01, 5'd2, 32'hFFFFFFF0);
    drive5(5'h01, 2'b10, 5'd3, 32'h08000000);
    drive5(5'h10, 2'b11, 5'd4, 32'hFFFFFFC0);
    repeat (3) @(posedge clk);
    #1;
    chk("n5_drained_occ", {30'b0, oc5}, 32'd0);
    chk("n5_queue_empty", 32'(exp5_data.size()), 32'd0);

    // Random valid/ready against the reference model.
    acc = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (acc) begin
        in_valid = 1'b0;
        acc      = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        in_mode  = 2'($urandom);
        in_tag   = 5'($urandom);
      end
      @(negedge clk);
      chk("rand_occ_le2", {31'b0, (occupancy <= 2'd2)}, 32'd1);
      chk("rand_valid_vs_occ", {31'b0, out_valid}, {31'b0, (occupancy != 2'd0)});
      if (in_valid && in_ready) begin
        exp_data.push_back(model(in_data, in_mode));
        exp_tag.push_back(in_tag);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_data.size()), 32'd0);
    chk("final_occ",         {30'b0, occupancy},   32'd0);
    chk("final_out_valid",   {31'b0, out_valid},   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
